// File: rtl/rca_word_sequencer_pkg.sv
// rca_word_sequencer_pkg: shared state codes and sizing constants for the nibble-serial adder
package rca_word_sequencer_pkg;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam int NIB_W = 4;
    localparam int NIBBLES_DEF = 4;
endpackage

// File: rtl/rca_word_sequencer_four_bit_rca.sv
// four_bit_rca: 4-bit ripple-carry adder shared by every nibble of the sequencer
module four_bit_rca (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);
    logic [4:0] c;
    assign c[0] = Cin;
    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_bit
            assign S[i]   = A[i] ^ B[i] ^ c[i];
            assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
    endgenerate
    assign Cout = c[4];
endmodule

// File: rtl/rca_word_sequencer.sv
// rca_word_sequencer: adds two W-bit words one nibble per cycle through a single 4-bit RCA
module rca_word_sequencer
    import rca_word_sequencer_pkg::*;
#(
    parameter int NIBBLES = NIBBLES_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [NIB_W*NIBBLES-1:0] a,
    input  logic [NIB_W*NIBBLES-1:0] b,
    input  logic                     cin,
    output logic                     busy,
    output logic                     done,
    output logic [NIB_W*NIBBLES-1:0] sum,
    output logic                     cout,
    output logic                     ovf
);
    localparam int W  = NIB_W * NIBBLES;
    localparam int IW = $clog2(NIBBLES);

    logic [1:0]       state;
    logic [IW-1:0]    idx;
    logic [W-1:0]     a_r, b_r, work;
    logic             cin_r, carry, co, last;
    logic [NIB_W-1:0] s;

    assign last = idx == IW'(NIBBLES - 1);
    assign busy = state == ADD;
    assign done = state == DONE;

    four_bit_rca u_rca (
        .A   (a_r[idx*NIB_W +: NIB_W]),
        .B   (b_r[idx*NIB_W +: NIB_W]),
        .Cin (idx == '0 ? cin_r : carry),
        .S   (s),
        .Cout(co)
    );

    // the final nibble goes straight to sum so partial words never reach the output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            a_r   <= '0;
            b_r   <= '0;
            cin_r <= 1'b0;
            carry <= 1'b0;
            work  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == ADD) begin
            work[idx*NIB_W +: NIB_W] <= s;
            carry <= co;
            idx   <= last ? '0 : idx + IW'(1);
            if (last) begin
                state <= DONE;
                sum   <= {s, work[W-NIB_W-1:0]};
                cout  <= co;
                ovf   <= (a_r[W-1] == b_r[W-1]) && (s[NIB_W-1] != a_r[W-1]);
            end
        end else if (start) begin
            state <= ADD;
            a_r   <= a;
            b_r   <= b;
            cin_r <= cin;
            idx   <= '0;
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_rca_word_sequencer.sv
// tb_rca_word_sequencer: directed vectors checked against a latency/arithmetic model every cycle
module tb_rca_word_sequencer;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;

    int total = 0;
    int bad = 0;

    rca_word_sequencer #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // model: an accepted request is the plain W+1-bit sum, published N cycles later
    int           rem = 0;
    logic [W:0]   res = '0;
    logic [W-1:0] oa = '0, ob = '0;
    logic         m_done = 1'b0, m_cout = 1'b0, m_ovf = 1'b0;
    logic [W-1:0] m_sum = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rem <= 0;
            m_done <= 1'b0;
            m_sum <= '0;
            m_cout <= 1'b0;
            m_ovf <= 1'b0;
        end else if (rem != 0) begin
            rem <= rem - 1;
            m_done <= (rem == 1);
            if (rem == 1) begin
                m_sum <= res[W-1:0];
                m_cout <= res[W];
                m_ovf <= (oa[W-1] == ob[W-1]) && (res[W-1] != oa[W-1]);
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                rem <= N;
                res <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                oa <= a;
                ob <= b;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if ({busy, done, sum, cout, ovf} !== {rem != 0, m_done, m_sum, m_cout, m_ovf}) begin
                bad++;
                $display("FAIL cycle t=%0t got busy=%b done=%b sum=%h cout=%b ovf=%b exp busy=%b done=%b sum=%h cout=%b ovf=%b",
                         $time, busy, done, sum, cout, ovf, rem != 0, m_done, m_sum, m_cout, m_ovf);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20);
    endtask

    task automatic op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic tc, input logic [W-1:0] es, input logic ec, input logic eo);
        int n;
        @(posedge clk); #2;
        a = ta; b = tb; cin = tc; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(n);
        chk({nm, "_latency"}, n, 5);
        chk({nm, "_result"}, {done, sum, cout, ovf}, {1'b1, es, ec, eo});
    endtask

    initial begin
        int n, m, pulses;
        rst = 1'b1;
        #8;
        chk("reset_state", {busy, done, sum, cout, ovf}, '0);
        #4 rst = 1'b0;

        op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        op("carry_in", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
        op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // busy lockout: second request lands mid-ADD and must vanish
        @(posedge clk); #2;
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk); #2;
        a = 16'h0F0F; b = 16'h0101; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                chk("lockout_sum", sum, 16'h3333);
            end
        end
        chk("lockout_pulses", pulses, 1);

        // back-to-back: start held through DONE
        @(posedge clk); #2;
        a = 16'h00FF; b = 16'h0F01; cin = 1'b0; start = 1'b1;
        @(posedge clk); #2;
        a = 16'h0001; b = 16'h0002;
        wait_done(n);
        chk("b2b_first", {n[7:0], sum}, {8'd5, 16'h1000});
        @(posedge clk); #2;
        start = 1'b0;
        m = 1;
        @(negedge clk);
        while (!done && m < 20) begin
            @(negedge clk);
            m++;
        end
        chk("b2b_second", {m[7:0], done, sum}, {8'd5, 1'b1, 16'h0003});

        // reset in the middle of an operation, with idx at 2
        @(posedge clk); #2;
        a = 16'h1111; b = 16'h1111; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1 chk("async_reset", {busy, done, sum, cout, ovf}, '0);
        @(posedge clk); #3;
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || sum != '0) pulses++;
        end
        chk("no_done_after_reset", pulses, 0);
        op("after_reset", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rca_word_sequencer.md
RCA_WORD_SEQUENCER -- requirements
Module: rca_word_sequencer

Interface
REQ-001 Parameter NIBBLES, default 4: number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 2..8.
REQ-002 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1: reset, asynchronous and active-high.
REQ-004 Port start, input, 1: request a new addition; sampled on the rising edge.
REQ-005 Port a, input, W: operand A; sampled only when start is accepted.
REQ-006 Port b, input, W: operand B; sampled only when start is accepted.
REQ-007 Port cin, input, 1: carry-in to nibble 0; sampled only when start is accepted.
REQ-008 Port busy, output, 1: high while nibbles are being added.
REQ-009 Port done, output, 1: single-cycle pulse; marks a valid result.
REQ-010 Port sum, output, W: registered result.
REQ-011 Port cout, output, 1: registered carry-out of the top nibble.
REQ-012 Port ovf, output, 1: registered two's-complement overflow flag.

Function
REQ-013 The block SHALL share one 4-bit ripple-carry adder across all nibbles, adding nibble i of A and B in ADD cycle i, least-significant nibble first.
REQ-014 The state machine SHALL have exactly three states: IDLE, ADD and DONE.
- IDLE: accepts start.
- ADD: advances the nibble index idx from 0 to NIBBLES-1.
- DONE: lasts one cycle.
REQ-015 On a rising edge with start=1 in IDLE or DONE, the block SHALL latch a, b and cin into internal registers, clear idx, and enter ADD.
REQ-016 Each ADD edge SHALL perform these updates:
- write the 4-bit adder sum into work-register nibble idx;
- load the adder carry-out into the carry register;
- increment idx.
REQ-017 The carry register SHALL feed the carry-in of the next nibble; nibble 0 SHALL use the latched cin.
REQ-018 On the ADD edge where idx=NIBBLES-1, the block SHALL enter DONE and update the outputs:
- sum: the complete work register;
- cout: the final carry;
- ovf: 1 iff latched A[W-1]==B[W-1] and the result bit W-1 differs from A[W-1].
REQ-019 Latency SHALL be fixed: for start accepted at edge N, busy=1 from edge N to edge N+NIBBLES, and done=1 for exactly the one cycle following edge N+NIBBLES.
REQ-020 busy SHALL be 1 only in ADD; done SHALL be 1 only in DONE.
REQ-021 start SHALL be ignored while in ADD, and the operands latched for the in-flight operation SHALL be unaffected.
REQ-022 With start=1 in DONE, the block SHALL go directly to ADD, giving back-to-back operations with no IDLE gap; otherwise DONE SHALL go to IDLE.
REQ-023 sum, cout and ovf SHALL hold their last result until the next DONE entry; intermediate nibbles SHALL never appear on sum.
REQ-024 Arithmetic SHALL be modulo 2^W, with the carry out of bit W-1 reported only on cout.

Reset
REQ-025 Asserting rst SHALL immediately force the following, regardless of clk:
- state to IDLE and idx to 0;
- the carry and work registers to 0;
- busy, done, sum, cout and ovf to 0.
REQ-026 A reset during ADD SHALL abandon the operation; no done pulse SHALL follow, and outputs SHALL stay 0 until a new operation completes.
REQ-027 The first rising edge after rst deasserts SHALL be able to accept start.

Structure
REQ-028 A shared package SHALL hold:
- the state enumeration (IDLE, ADD, DONE);
- the nibble width constant 4;
- the default NIBBLES value.
REQ-029 The design SHALL instantiate exactly one sub-module, four_bit_rca, with ports (A, B, Cin, S, Cout); nibble selection muxing SHALL remain in the sequencer.

Verification
REQ-030 Carry ripple: NIBBLES=4, a=0xFFFF, b=0x0001, cin=0, start at edge N -> sum=0x0000, cout=1, ovf=0, done high only after edge N+4.
REQ-031 Carry-in: a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0, ovf=0.
REQ-032 Overflow: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, ovf=1, cout=0; then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
REQ-033 Busy lockout: during ADD, pulse start with a=0x0F0F, b=0x0101 -> ignored; the in-flight result completes unchanged and exactly one done pulse occurs.
REQ-034 Back-to-back: hold start=1 through DONE with a=0x0001, b=0x0002 -> first result, then sum=0x0003 exactly 5 cycles after the first done.
REQ-035 Reset mid-operation: assert rst at idx=2 -> all outputs 0 asynchronously, no done pulse, and a next start yields a correct result.
